// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and timing constants for the radix-4 Booth multiplier
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Magnitude select (one/two) plus negate; all zero means a zero digit.
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

  function automatic int booth_calc_cycles(input int n);
    return n / 2 + 1;
  endfunction

  // Rising edges from the accepting edge to the edge that raises done.
  function automatic int booth_latency(input int n);
    return booth_calc_cycles(n) + 1;
  endfunction

endpackage

// File: rtl/booth_radix4_mult_if.sv
// rtl/booth_radix4_mult_if.sv - request/result bundle between a requester and the multiplier
interface booth_radix4_mult_if #(
  parameter int N = 32
);
  logic           start;
  logic           signed_mode;
  logic [N-1:0]   m;
  logic [N-1:0]   q;
  logic           busy;
  logic           done;
  logic [2*N-1:0] P;

  modport master (
    output start, signed_mode, m, q,
    input  busy, done, P
  );

  modport slave (
    input  start, signed_mode, m, q,
    output busy, done, P
  );
endinterface

// File: rtl/booth_r4_encoder.sv
// rtl/booth_r4_encoder.sv - maps a multiplier triplet {q[i+1], q[i], q[i-1]} to a Booth digit
module booth_r4_encoder
  import booth_pkg::*;
(
  input  logic [2:0]   trip,
  output booth_digit_t digit
);

  always_comb begin
    digit = '0;
    case (trip)
      3'b001, 3'b010: digit = '{neg: 1'b0, one: 1'b1, two: 1'b0};
      3'b011:         digit = '{neg: 1'b0, one: 1'b0, two: 1'b1};
      3'b100:         digit = '{neg: 1'b1, one: 1'b0, two: 1'b1};
      3'b101, 3'b110: digit = '{neg: 1'b1, one: 1'b1, two: 1'b0};
      default:        digit = '0;
    endcase
  end

endmodule

// File: rtl/booth_radix4_mult.sv
// rtl/booth_radix4_mult.sv - sequential radix-4 Booth multiplier, one digit per cycle
// Operands are extended to N+2 bits so one datapath serves signed and unsigned modes.
module booth_radix4_mult
  import booth_pkg::*;
#(
  parameter int N = 32
) (
  input logic                clk,
  input logic                rst,
  booth_radix4_mult_if.slave bus
);

  localparam int XW   = N + 2;
  localparam int HW   = N + 4;
  localparam int CW   = $clog2(N / 2 + 1) + 1;
  localparam logic [CW-1:0] LAST = CW'(booth_calc_cycles(N) - 1);

  state_t          state;
  logic [XW-1:0]   mcand;
  logic [HW-1:0]   hi;
  logic [XW-1:0]   lo;
  logic            qm1;
  logic [CW-1:0]   cnt;

  booth_digit_t    dig;
  logic [HW-1:0]   m_ext;
  logic [HW-1:0]   mag;
  logic [HW-1:0]   addend;
  logic [HW-1:0]   sum;
  logic [XW-1:0]   m_cap;
  logic [XW-1:0]   q_cap;
  logic            accept;

  booth_r4_encoder u_enc (
    .trip  ({lo[1:0], qm1}),
    .digit (dig)
  );

  assign m_cap  = bus.signed_mode ? {{2{bus.m[N-1]}}, bus.m} : {2'b00, bus.m};
  assign q_cap  = bus.signed_mode ? {{2{bus.q[N-1]}}, bus.q} : {2'b00, bus.q};
  assign accept = bus.start && (state != CALC);
  assign m_ext  = {{2{mcand[XW-1]}}, mcand};

  // Single shared adder: subtraction is invert-plus-carry-in.
  always_comb begin
    mag = '0;
    if (dig.two) begin
      mag = m_ext << 1;
    end else if (dig.one) begin
      mag = m_ext;
    end
    addend = dig.neg ? ~mag : mag;
    sum    = hi + addend + HW'(dig.neg);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.P    <= '0;
      mcand    <= '0;
      hi       <= '0;
      lo       <= '0;
      qm1      <= 1'b0;
      cnt      <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: state <= IDLE;
        CALC: begin
          // {hi, lo, qm1} shifts right by two; consumed multiplier bits fall out of lo.
          hi  <= {{2{sum[HW-1]}}, sum[HW-1:2]};
          lo  <= {sum[1:0], lo[XW-1:2]};
          qm1 <= lo[1];
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state    <= DONE;
            bus.busy <= 1'b0;
          end
        end
        DONE: begin
          bus.P    <= {hi[N-3:0], lo};
          bus.done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        mcand    <= m_cap;
        hi       <= '0;
        lo       <= q_cap;
        qm1      <= 1'b0;
        cnt      <= '0;
        state    <= CALC;
        bus.busy <= 1'b1;
      end
    end
  end

endmodule
